// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the fetch sequencer and its target calculator.
package fetch_pkg;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_J   = 2'b10;
    localparam logic [1:0] PC_SRC_JR  = 2'b11;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_sequencer_npc_calc.sv
// Combinational next-PC target selection plus word-alignment check.
module npc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic            br_taken,
    input  logic [XLEN-1:0] imm32,
    input  logic [25:0]     jtarget,
    input  logic [XLEN-1:0] jr_addr,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] pc4;

    assign pc4 = pc + XLEN'(PC_INC);

    always_comb begin
        target = pc4;
        case (pc_src)
            PC_SRC_SEQ: target = pc4;
            PC_SRC_BR:  target = br_taken ? pc4 + (imm32 << BR_SHIFT) : pc4;
            PC_SRC_J:   target = {pc4[XLEN-1:28], jtarget, 2'b00};
            PC_SRC_JR:  target = jr_addr;
            default:    target = pc4;
        endcase
    end

    assign misalign = (target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches the instruction at PC over a ready handshake and steers NextPC back to the PC register.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] NextPC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic            br_taken,
    input  logic [XLEN-1:0] imm32,
    input  logic [25:0]     jtarget,
    input  logic [XLEN-1:0] jr_addr,
    output logic            fetch_err
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    state_t          state, state_d;
    logic [CW-1:0]   wait_cnt;
    logic            started;
    logic            capture;
    logic            raise_err;
    logic [XLEN-1:0] target;
    logic            misalign;

    npc_calc #(
        .XLEN     (XLEN),
        .BR_SHIFT (BR_SHIFT)
    ) u_npc (
        .pc       (PC),
        .pc_src   (pc_src),
        .br_taken (br_taken),
        .imm32    (imm32),
        .jtarget  (jtarget),
        .jr_addr  (jr_addr),
        .target   (target),
        .misalign (misalign)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= ST_FETCH;
        else        state <= state_d;
    end

    // The first clock after reset release only arms the fetch; no request is issued before it.
    always_comb begin
        state_d   = state;
        capture   = 1'b0;
        raise_err = 1'b0;
        case (state)
            ST_FETCH: begin
                if (started) begin
                    if (imem_ready) begin
                        capture = 1'b1;
                        state_d = ST_EXEC;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        raise_err = 1'b1;
                        state_d   = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (misalign) begin
                        raise_err = 1'b1;
                        state_d   = ST_ERR;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        NextPC      = PC;
        case (state)
            ST_FETCH: imem_req = started;
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!stall && !misalign) NextPC = target;
            end
            default: ;
        endcase
    end

    assign imem_addr = PC;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            started   <= 1'b0;
            wait_cnt  <= '0;
            instr     <= '0;
            fetch_err <= 1'b0;
        end else begin
            started <= 1'b1;
            if (raise_err) fetch_err <= 1'b1;
            if (capture) begin
                instr    <= imem_rdata;
                wait_cnt <= '0;
            end else if (state == ST_FETCH && started) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: acts as PC register and instruction memory around fetch_sequencer.
module tb_fetch_sequencer;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 16;

    logic            CLK = 1'b0;
    logic            Reset;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NextPC;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            stall;
    logic [1:0]      pc_src;
    logic            br_taken;
    logic [XLEN-1:0] imm32;
    logic [25:0]     jtarget;
    logic [XLEN-1:0] jr_addr;
    logic            fetch_err;

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] npc_s;
    logic [XLEN-1:0] expv;
    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .XLEN     (XLEN),
        .TIMEOUT  (TIMEOUT),
        .BR_SHIFT (2)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PC          (PC),
        .NextPC      (NextPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .pc_src      (pc_src),
        .br_taken    (br_taken),
        .imm32       (imm32),
        .jtarget     (jtarget),
        .jr_addr     (jr_addr),
        .fetch_err   (fetch_err)
    );

    always #5 CLK = ~CLK;

    // One cycle: sample NextPC before the edge, load it into PC at the following negedge.
    task automatic tick();
        #1 npc_s = NextPC;
        @(posedge CLK);
        @(negedge CLK);
        PC = npc_s;
    endtask

    task automatic fetch_exec(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] word);
        PC         = pc;
        imem_ready = 1'b1;
        imem_rdata = word;
        exp_q.push_back(word);
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic test_reset();
        Reset = 1'b0; PC = 32'h40; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
        pc_src = 2'b00; br_taken = 1'b0; imm32 = '0; jtarget = '0; jr_addr = '0;
        #3;
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (fetch_err !== 1'b0)    begin errors++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
        checks++; if (instr !== 32'h0)       begin errors++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (NextPC !== 32'h40)     begin errors++; $display("FAIL rst_npc got=%h exp=40", NextPC); end
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rel_req got=%b exp=0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL arm_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h40)  begin errors++; $display("FAIL arm_addr got=%h exp=40", imem_addr); end
    endtask

    task automatic test_seq();
        fetch_exec(32'h0, 32'hA0A0_0001);
        pc_src = 2'b00; stall = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got=%b exp=1", instr_valid); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL seq_sb got=empty exp=entry"); end
        else begin expv = exp_q.pop_front(); if (instr !== expv) begin errors++; $display("FAIL seq_instr got=%h exp=%h", instr, expv); end end
        checks++; if (NextPC !== 32'h4)     begin errors++; $display("FAIL seq_npc got=%h exp=4", NextPC); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4)
            begin errors++; $display("FAIL seq_refetch got=%b/%h exp=1/4", imem_req, imem_addr); end
    endtask

    task automatic test_branch();
        fetch_exec(32'h100, 32'hB000_0002);
        pc_src = 2'b01; br_taken = 1'b1; imm32 = 32'hFFFF_FFFE; stall = 1'b0;
        #1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL br_sb got=empty exp=entry"); end
        else begin expv = exp_q.pop_front(); if (instr !== expv) begin errors++; $display("FAIL br_instr got=%h exp=%h", instr, expv); end end
        checks++; if (NextPC !== 32'h0FC) begin errors++; $display("FAIL br_taken got=%h exp=fc", NextPC); end
        br_taken = 1'b0;
        #1;
        checks++; if (NextPC !== 32'h104) begin errors++; $display("FAIL br_not got=%h exp=104", NextPC); end
        tick();
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL br_addr got=%h exp=104", imem_addr); end
    endtask

    task automatic test_jump();
        fetch_exec(32'h1000_0000, 32'hC000_0003);
        pc_src = 2'b10; jtarget = 26'h0000040; stall = 1'b0;
        #1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL j_sb got=empty exp=entry"); end
        else begin expv = exp_q.pop_front(); if (instr !== expv) begin errors++; $display("FAIL j_instr got=%h exp=%h", instr, expv); end end
        checks++; if (NextPC !== 32'h1000_0100) begin errors++; $display("FAIL j_npc got=%h exp=10000100", NextPC); end
        pc_src = 2'b11; jr_addr = 32'h200;
        #1;
        checks++; if (NextPC !== 32'h200) begin errors++; $display("FAIL jr_npc got=%h exp=200", NextPC); end
        tick();
    endtask

    task automatic test_wait();
        int nreq;
        nreq = 0;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (imem_req === 1'b1) nreq++;
            checks++; if (NextPC !== PC || instr_valid !== 1'b0)
                begin errors++; $display("FAIL wait_hold got=%h/%b exp=%h/0", NextPC, instr_valid, PC); end
            tick();
        end
        imem_ready = 1'b1; imem_rdata = 32'hD000_0004; exp_q.push_back(32'hD000_0004);
        #1;
        if (imem_req === 1'b1) nreq++;
        checks++; if (NextPC !== PC) begin errors++; $display("FAIL wait_last got=%h exp=%h", NextPC, PC); end
        tick();
        imem_ready = 1'b0;
        checks++; if (nreq != 4) begin errors++; $display("FAIL wait_reqs got=%0d exp=4", nreq); end
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] held;
        held = '0;
        stall = 1'b1; pc_src = 2'b00;
        for (int i = 0; i < 2; i++) begin
            imem_ready = 1'b1;
            #1;
            checks++; if (instr_valid !== 1'b1 || NextPC !== PC)
                begin errors++; $display("FAIL stall_hold got=%b/%h exp=1/%h", instr_valid, NextPC, PC); end
            if (i == 0) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL stall_sb got=empty exp=entry"); end
                else begin expv = exp_q.pop_front(); held = expv; if (instr !== expv) begin errors++; $display("FAIL stall_instr got=%h exp=%h", instr, expv); end end
            end else begin
                checks++; if (instr !== held) begin errors++; $display("FAIL stall_held got=%h exp=%h", instr, held); end
            end
            tick();
        end
        imem_ready = 1'b0; stall = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b1 || NextPC !== PC + 32'h4)
            begin errors++; $display("FAIL stall_rel got=%b/%h exp=1/%h", instr_valid, NextPC, PC + 32'h4); end
        tick();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1)
            begin errors++; $display("FAIL stall_after got=%b/%b exp=0/1", instr_valid, imem_req); end
    endtask

    task automatic test_timeout();
        int nreq;
        nreq = 0;
        imem_ready = 1'b0;
        for (int n = 0; n < int'(TIMEOUT) + 8 && fetch_err !== 1'b1; n++) begin
            #1;
            if (imem_req === 1'b1) nreq++;
            tick();
        end
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", fetch_err); end
        checks++; if (nreq != int'(TIMEOUT)) begin errors++; $display("FAIL to_reqs got=%0d exp=%0d", nreq, TIMEOUT); end
        imem_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1 || NextPC !== PC)
                begin errors++; $display("FAIL err_hold got=%b%b%b/%h exp=001/%h", imem_req, instr_valid, fetch_err, NextPC, PC); end
            tick();
        end
        imem_ready = 1'b0;
        Reset = 1'b0;
        #1;
        checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL err_rst got=%b/%b exp=0/0", fetch_err, imem_req); end
        @(negedge CLK);
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_misalign();
        fetch_exec(32'h300, 32'hE000_0005);
        pc_src = 2'b11; jr_addr = 32'h202; stall = 1'b0;
        #1;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL mis_sb got=empty exp=entry"); end
        else begin expv = exp_q.pop_front(); if (instr !== expv) begin errors++; $display("FAIL mis_instr got=%h exp=%h", instr, expv); end end
        checks++; if (instr_valid !== 1'b1 || NextPC !== 32'h300)
            begin errors++; $display("FAIL mis_npc got=%b/%h exp=1/300", instr_valid, NextPC); end
        tick();
        checks++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || NextPC !== 32'h300)
            begin errors++; $display("FAIL mis_err got=%b%b%b/%h exp=100/300", fetch_err, instr_valid, imem_req, NextPC); end
        Reset = 1'b0;
        #1;
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL mis_rst got=%b exp=0", fetch_err); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_wait();
        test_stall();
        test_timeout();
        test_misalign();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_left got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
